// File: rtl/uart_tx_ctrl_pkg.sv
// uart_tx_pkg -- shared constants for the UART transmit frame sequencer.
//   * FSM state codes (IDLE/START/DATA/PARITY/STOP)
//   * Output bit-mux select codes (MUX_IDLE/MUX_START/MUX_DATA/MUX_PAR)
//   * Parity type codes (PAR_EVEN/PAR_ODD)
//   * state_to_mux(): line level source selected while in a given state
package uart_tx_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [1:0] MUX_IDLE  = 2'd0;
    localparam logic [1:0] MUX_START = 2'd1;
    localparam logic [1:0] MUX_DATA  = 2'd2;
    localparam logic [1:0] MUX_PAR   = 2'd3;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Stop bits and idle share the same '1' level source.
    function automatic logic [1:0] state_to_mux(input logic [2:0] st);
        case (st)
            START:   return MUX_START;
            DATA:    return MUX_DATA;
            PARITY:  return MUX_PAR;
            default: return MUX_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if -- host-side byte handshake of the UART transmitter.
//   DATA_VALID  host offers a byte
//   P_DATA      byte to send
//   PAR_EN      1 = insert parity bit
//   PAR_TYP     0 = even, 1 = odd
//   data_ready  controller can accept a byte this cycle
// master: host side; slave: uart_tx_ctrl.
interface uart_tx_ctrl_if;

    logic       DATA_VALID;
    logic [7:0] P_DATA;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       data_ready;

    modport master (output DATA_VALID, P_DATA, PAR_EN, PAR_TYP, input data_ready);
    modport slave  (input DATA_VALID, P_DATA, PAR_EN, PAR_TYP, output data_ready);

endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer -- prescale counter that marks the end of each UART bit.
//   CLK, RST  clock / asynchronous active-low reset
//   en        count while a frame is in progress
//   clear     restart the bit period (state change)
//   bit_end   last cycle of the current bit period
module uart_bit_timer #(
    parameter int PRESCALE = 8,
    parameter int PRESC_W  = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic clear,
    output logic bit_end
);

    logic [PRESC_W-1:0] cnt;

    assign bit_end = en && (cnt == PRESC_W'(PRESCALE - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values present before the clock edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl -- UART transmit frame sequencer.
//   CLK, RST     clock / asynchronous active-low reset
//   host         byte handshake (uart_tx_ctrl_if.slave)
//   ser_pdata    latched byte to the serializer
//   ser_par_typ  latched parity type to the parity calculator
//   ser_en       one-cycle advance pulse to the serializer
//   ser_data     current serial data bit from the serializer
//   ser_done     serializer is presenting its 8th bit
//   par_bit      parity bit from the parity calculator
//   mux_sel      registered line source select
//   TX_OUT       serial line
//   busy         frame in progress
// Build option: UART_TX_TWO_STOP_EN -- two stop bits instead of one.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int PRESCALE = 8,
    parameter int PRESC_W  = 8
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_ctrl_if.slave host,
    output logic [7:0]    ser_pdata,
    output logic          ser_par_typ,
    output logic          ser_en,
    input  logic          ser_data,
    input  logic          ser_done,
    input  logic          par_bit,
    output logic [1:0]    mux_sel,
    output logic          TX_OUT,
    output logic          busy
);

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [2:0] bit_idx;
    logic       par_en_q;
    logic       bit_end;
    logic       last_stop;
    logic       data_last;
    logic       ready;
    logic       accept;

    uart_bit_timer #(
        .PRESCALE(PRESCALE),
        .PRESC_W (PRESC_W)
    ) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .en     (busy),
        .clear  (state_d != state_q),
        .bit_end(bit_end)
    );

`ifdef UART_TX_TWO_STOP_EN
    logic stop_idx;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stop_idx <= 1'b0;
        end else if (state_q != STOP) begin
            stop_idx <= 1'b0;
        end else if (bit_end) begin
            stop_idx <= ~stop_idx;
        end
    end

    assign last_stop = stop_idx;
`else
    assign last_stop = 1'b1;
`endif

    assign busy            = (state_q != IDLE);
    assign ready           = (state_q == IDLE) || ((state_q == STOP) && bit_end && last_stop);
    assign host.data_ready = ready;
    assign accept          = host.DATA_VALID && ready;

    // Leave DATA after the 8th bit even if ser_done never shows up.
    assign data_last = bit_end && (ser_done || (bit_idx == 3'd7));

    // Advance pulses: end of START, then end of every data bit except the last.
    assign ser_en = bit_end && ((state_q == START) || ((state_q == DATA) && !data_last));

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (data_last) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end && last_stop) state_d = accept ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the byte/config latch is reset along with the FSM so the
    // serializer sees known values straight out of reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            mux_sel     <= MUX_IDLE;
            ser_pdata   <= 8'h00;
            ser_par_typ <= PAR_EVEN;
            par_en_q    <= 1'b0;
            bit_idx     <= 3'd0;
        end else begin
            state_q <= state_d;
            // Registered from the next state so the line switches with the state.
            mux_sel <= state_to_mux(state_d);
            if (accept) begin
                ser_pdata   <= host.P_DATA;
                ser_par_typ <= host.PAR_TYP;
                par_en_q    <= host.PAR_EN;
            end
            if (state_q != DATA) begin
                bit_idx <= 3'd0;
            end else if (bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // mux_sel resets asynchronously to MUX_IDLE, which forces the line high.
    always_comb begin
        TX_OUT = 1'b1;
        case (mux_sel)
            MUX_START: TX_OUT = 1'b0;
            MUX_DATA:  TX_OUT = ser_data;
            MUX_PAR:   TX_OUT = par_bit;
            default:   TX_OUT = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl -- self-checking bench for uart_tx_ctrl (PRESCALE = 4).
// Models the serializer and parity calculator, keeps a queue of expected
// frames and checks the line cycle by cycle against them.
// Honours UART_TX_TWO_STOP_EN for the expected stop length.
module tb_uart_tx_ctrl;
    import uart_tx_pkg::*;

    localparam int P = 4;
`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       pt;
    } frame_t;

    logic       CLK;
    logic       RST;
    logic [7:0] ser_pdata;
    logic       ser_par_typ;
    logic       ser_en;
    logic       ser_data;
    logic       ser_done;
    logic       par_bit;
    logic [1:0] mux_sel;
    logic       TX_OUT;
    logic       busy;

    uart_tx_ctrl_if bus ();

    uart_tx_ctrl #(.PRESCALE(P), .PRESC_W(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .host       (bus.slave),
        .ser_pdata  (ser_pdata),
        .ser_par_typ(ser_par_typ),
        .ser_en     (ser_en),
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .par_bit    (par_bit),
        .mux_sel    (mux_sel),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Serializer model: each ser_en presents the next bit, wrapping per frame.
    logic [3:0] ser_cnt;
    logic [3:0] ser_idx;
    bit         no_done;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) ser_cnt <= 4'd0;
        else if (ser_en) ser_cnt <= (ser_cnt == 4'd8) ? 4'd1 : ser_cnt + 4'd1;
    end

    always_comb begin
        ser_idx  = ser_cnt - 4'd1;
        ser_data = (ser_cnt >= 4'd1 && ser_cnt <= 4'd8) ? ser_pdata[ser_idx[2:0]] : 1'b0;
        ser_done = !no_done && (ser_cnt == 4'd8);
        par_bit  = (^ser_pdata) ^ ser_par_typ;
    end

    int     checks = 0;
    int     errors = 0;
    frame_t sb[$];

    bit     mon_en = 0;
    bit     check_pulses = 1;
    int     frames_done = 0;
    int     gap = 0;
    int     last_gap = -1;
    int     busy_run = 0;
    int     last_busy_run = 0;

    // Line monitor: pops a frame at each start bit and checks every cycle.
    initial begin
        bit     active;
        int     cyc;
        int     nbits;
        int     pulses;
        logic   exp_bits[0:11];
        logic   exp_rdy;
        frame_t f;
        active = 0;
        cyc = 0;
        nbits = 0;
        pulses = 0;
        forever begin
            @(negedge CLK);
            if (!mon_en) begin
                active   = 0;
                gap      = 0;
                busy_run = 0;
            end else begin
                if (busy === 1'b1) busy_run++;
                else if (busy_run != 0) begin
                    last_busy_run = busy_run;
                    busy_run      = 0;
                end
                if (!active && TX_OUT === 1'b0) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start at %0t: line low with no byte queued", $time);
                    end else begin
                        f = sb.pop_front();
                        exp_bits[0] = 1'b0;
                        for (int i = 0; i < 8; i++) exp_bits[1+i] = f.d[i];
                        nbits = 9;
                        if (f.pe) begin
                            exp_bits[nbits] = (^f.d) ^ f.pt;
                            nbits++;
                        end
                        for (int i = 0; i < STOP_BITS; i++) begin
                            exp_bits[nbits] = 1'b1;
                            nbits++;
                        end
                        active   = 1;
                        cyc      = 0;
                        pulses   = 0;
                        last_gap = gap;
                    end
                end
                if (active) begin
                    checks++;
                    if (TX_OUT !== exp_bits[cyc / P]) begin
                        errors++;
                        $display("FAIL tx_bit byte %h cycle %0d: got %b want %b", f.d, cyc, TX_OUT, exp_bits[cyc / P]);
                    end
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL busy_in_frame cycle %0d: got %b want 1", cyc, busy);
                    end
                    exp_rdy = (cyc == nbits * P - 1);
                    checks++;
                    if (bus.data_ready !== exp_rdy) begin
                        errors++;
                        $display("FAIL ready_in_frame cycle %0d: got %b want %b", cyc, bus.data_ready, exp_rdy);
                    end
                    if (ser_en === 1'b1) pulses++;
                    cyc++;
                    if (cyc == nbits * P) begin
                        active = 0;
                        gap    = 0;
                        frames_done++;
                        if (check_pulses) begin
                            checks++;
                            if (pulses != 8) begin
                                errors++;
                                $display("FAIL ser_en_count byte %h: got %0d want 8", f.d, pulses);
                            end
                        end
                    end
                end else begin
                    checks++;
                    if (TX_OUT !== 1'b1 || busy !== 1'b0 || bus.data_ready !== 1'b1 || ser_en !== 1'b0) begin
                        errors++;
                        $display("FAIL idle_outputs at %0t: tx %b busy %b ready %b ser_en %b want 1 0 1 0",
                                 $time, TX_OUT, busy, bus.data_ready, ser_en);
                    end
                    gap++;
                end
            end
        end
    end

    // Offer a byte (called at a negedge); returns at the negedge after acceptance
    // with DATA_VALID still high so a following call can run back-to-back.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        frame_t f;
        bit     ok;
        ok = 0;
        bus.DATA_VALID = 1'b1;
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        for (int i = 0; i < 200; i++) begin
            if (bus.data_ready === 1'b1) begin
                f.d  = d;
                f.pe = pe;
                f.pt = pt;
                sb.push_back(f);
                @(posedge CLK);
                @(negedge CLK);
                ok = 1;
                break;
            end
            @(negedge CLK);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout byte %h: data_ready never seen", d);
        end
    endtask

    task automatic wait_frames(input int target);
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (frames_done >= target) begin
                ok = 1;
                break;
            end
            @(negedge CLK);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: frames %0d want %0d", frames_done, target);
        end
    endtask

    task automatic test_reset();
        RST            = 1'b0;
        bus.DATA_VALID = 1'b0;
        bus.P_DATA     = 8'h00;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        no_done        = 0;
        repeat (3) @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0 || bus.data_ready !== 1'b1 || ser_en !== 1'b0 || mux_sel !== MUX_IDLE) begin
            errors++;
            $display("FAIL reset_ctrl: tx %b busy %b ready %b ser_en %b mux %0d want 1 0 1 0 0",
                     TX_OUT, busy, bus.data_ready, ser_en, mux_sel);
        end
        checks++;
        if (ser_pdata !== 8'h00 || ser_par_typ !== 1'b0) begin
            errors++;
            $display("FAIL reset_latch: pdata %h par_typ %b want 00 0", ser_pdata, ser_par_typ);
        end
        RST = 1'b1;
        @(posedge CLK);
        mon_en = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            checks++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0 || bus.data_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_after_reset cycle %0d: tx %b busy %b ready %b want 1 0 1",
                         i, TX_OUT, busy, bus.data_ready);
            end
        end
    endtask

    task automatic test_basic();
        int target;
        target = frames_done + 1;
        send(8'hA5, 1'b0, PAR_EVEN);
        bus.DATA_VALID = 1'b0;
        wait_frames(target);
        repeat (3) @(negedge CLK);
        checks++;
        if (last_busy_run != P * (9 + STOP_BITS)) begin
            errors++;
            $display("FAIL frame_len_a5: got %0d want %0d", last_busy_run, P * (9 + STOP_BITS));
        end
    endtask

    task automatic test_parity(input logic pt, input logic exp_par);
        int target;
        target = frames_done + 1;
        send(8'h07, 1'b1, pt);
        bus.DATA_VALID = 1'b0;
        // Now in cycle 0 of the frame; parity bit occupies cycles 36..39.
        repeat (37) @(negedge CLK);
        checks++;
        if (TX_OUT !== exp_par) begin
            errors++;
            $display("FAIL parity_bit typ %b: got %b want %b", pt, TX_OUT, exp_par);
        end
        wait_frames(target);
        repeat (3) @(negedge CLK);
        checks++;
        if (last_busy_run != P * (10 + STOP_BITS)) begin
            errors++;
            $display("FAIL frame_len_parity: got %0d want %0d", last_busy_run, P * (10 + STOP_BITS));
        end
    endtask

    task automatic test_back_to_back();
        int target;
        target = frames_done + 2;
        send(8'h55, 1'b0, PAR_EVEN);
        // Offering the next byte changes P_DATA while the first frame runs.
        send(8'hFF, 1'b0, PAR_EVEN);
        bus.DATA_VALID = 1'b0;
        bus.P_DATA     = 8'h12;
        bus.PAR_EN     = 1'b1;
        wait_frames(target);
        checks++;
        if (last_gap != 0) begin
            errors++;
            $display("FAIL b2b_gap: got %0d idle cycles want 0", last_gap);
        end
        bus.PAR_EN = 1'b0;
    endtask

    task automatic test_ser_done_stuck();
        int target;
        target       = frames_done + 1;
        no_done      = 1;
        check_pulses = 0;
        send(8'hC3, 1'b1, PAR_ODD);
        bus.DATA_VALID = 1'b0;
        wait_frames(target);
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stuck_done_end: busy %b want 0", busy);
        end
        no_done      = 0;
        check_pulses = 1;
    endtask

    task automatic test_reset_mid_frame();
        send(8'h3C, 1'b0, PAR_EVEN);
        bus.DATA_VALID = 1'b0;
        repeat (10) @(negedge CLK);
        mon_en = 0;
        checks++;
        if (mux_sel !== MUX_DATA) begin
            errors++;
            $display("FAIL mid_frame_state: mux %0d want %0d", mux_sel, MUX_DATA);
        end
        #2 RST = 1'b0;
        #1;
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0 || bus.data_ready !== 1'b1 || mux_sel !== MUX_IDLE) begin
            errors++;
            $display("FAIL reset_mid_frame: tx %b busy %b ready %b mux %0d want 1 0 1 0",
                     TX_OUT, busy, bus.data_ready, mux_sel);
        end
        sb.delete();
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        mon_en = 1;
        repeat (5) @(negedge CLK);
    endtask

    task automatic test_two_stop();
        int target;
        target = frames_done + 1;
        send(8'h00, 1'b0, PAR_EVEN);
        bus.DATA_VALID = 1'b0;
        wait_frames(target);
        repeat (3) @(negedge CLK);
        checks++;
        if (last_busy_run != P * (9 + STOP_BITS)) begin
            errors++;
            $display("FAIL frame_len_00: got %0d want %0d", last_busy_run, P * (9 + STOP_BITS));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity(PAR_EVEN, 1'b1);
        test_parity(PAR_ODD, 1'b0);
        test_back_to_back();
        test_ser_done_stuck();
        test_reset_mid_frame();
        test_two_stop();
        repeat (5) @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d frames never seen", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmitter. It accepts a byte with a valid/ready handshake and latches the byte and the parity configuration. It then drives the serializer (ser_en pulses), the parity calculator and the output bit mux so that TX_OUT carries start, 8 data bits LSB-first, optional parity and stop. It owns all bit timing through an internal prescaler and sits between the host-side interface and the serializer/parity datapath.

Parameters:
PRESCALE, 8, CLK cycles per UART bit; legal range 2..255.
PRESC_W, 8, width of the prescale counter; must satisfy 2^PRESC_W > PRESCALE.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
DATA_VALID  in  1  byte offered on P_DATA
P_DATA  in  8  byte to send
PAR_EN  in  1  1 = insert parity bit
PAR_TYP  in  1  0 = even, 1 = odd
data_ready  out  1  controller can accept a byte this cycle
ser_pdata  out  8  latched byte to serializer, stable for the whole frame
ser_par_typ  out  1  latched PAR_TYP to parity calculator
ser_en  out  1  one-cycle advance pulse to serializer
ser_data  in  1  current serial data bit from serializer
ser_done  in  1  serializer has presented its 8th bit
par_bit  in  1  parity bit from parity calculator
mux_sel  out  2  0 = idle '1', 1 = start '0', 2 = ser_data, 3 = par_bit
TX_OUT  out  1  serial line, combinational mux of registered mux_sel and inputs
busy  out  1  frame in progress

Behaviour:
- Reset: state IDLE, mux_sel = 0, TX_OUT = 1, ser_en = 0, busy = 0, data_ready = 1, ser_pdata = 0, ser_par_typ = 0, prescale counter = 0.
- States: IDLE, START, DATA, PARITY, STOP. Each non-IDLE state lasts exactly PRESCALE cycles, timed by the prescale counter (0..PRESCALE-1). The counter clears on every state change.
- data_ready = 1 in IDLE, and in the last cycle of STOP (last stop bit when the optional feature is on).
- Accept: DATA_VALID & data_ready. The next cycle moves to START and latches P_DATA, PAR_EN and PAR_TYP. A change on P_DATA, PAR_EN or PAR_TYP mid-frame has no effect.
- Back-to-back: an accept in the last STOP cycle goes directly to START with no idle gap.
- busy = 1 in every state except IDLE.
- Transitions:
  - IDLE -> START on accept.
  - START -> DATA at end of bit period.
  - DATA -> PARITY (latched PAR_EN = 1) or STOP (PAR_EN = 0) at end of a bit period where ser_done = 1.
  - PARITY -> STOP at end of bit period.
  - STOP -> IDLE, or STOP -> START if a byte is accepted.
- ser_en is pulsed for one cycle in the last cycle of START and in the last cycle of each DATA bit period while ser_done = 0. This gives exactly 8 pulses per frame. ser_data must be valid from the first cycle of each data bit.
- mux_sel is registered and updates in the same cycle the state changes. TX_OUT has no glitch at bit boundaries beyond the source bit change.
- Frame length: PRESCALE × (10 + PAR_EN) cycles.
- Safety: if ser_done is not seen within 8 data bit periods, force the transition to the next state after the 8th bit. The serializer handshake cannot hang the FSM.
- Reset mid-frame returns to IDLE immediately; TX_OUT = 1 asynchronously.

Optional Feature:
UART_TX_TWO_STOP_EN:
- Defined: STOP lasts 2 × PRESCALE cycles (two stop bits); data_ready is asserted only in the final cycle of the second stop bit.
- Undefined: exactly one stop bit.

Decomposition:
- Shared package uart_tx_pkg: state enum (IDLE/START/DATA/PARITY/STOP), mux_sel encodings (MUX_IDLE = 0, MUX_START = 1, MUX_DATA = 2, MUX_PAR = 3), PAR_EVEN = 0 / PAR_ODD = 1.
- One sub-module: uart_bit_timer (prescale counter with bit_end output and clear input). FSM and mux stay in the top.

Test Plan:
- Reset then idle: with PRESCALE = 4, hold RST low, release, no DATA_VALID -> TX_OUT = 1, busy = 0, data_ready = 1 for 50 cycles.
- Byte 0xA5, PAR_EN = 0 -> TX_OUT shows 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 total); exactly 8 ser_en pulses; busy falls after 40 cycles.
- Byte 0x07, PAR_EN = 1, PAR_TYP = 0 -> parity bit 1; with PAR_TYP = 1 -> parity bit 0; frame length 44 cycles.
- Back-to-back 0x55 then 0xFF, DATA_VALID held -> second start bit immediately follows the first stop bit, no idle cycle; P_DATA changed mid-frame is ignored.
- ser_done tied 0 -> FSM leaves DATA after 8 bit periods and the frame completes normally. Assert RST mid-DATA -> TX_OUT = 1 and state IDLE the same cycle.
- UART_TX_TWO_STOP_EN defined, byte 0x00 -> stop level held 8 cycles; data_ready asserted only in the last stop cycle.
